// File: rtl/wb_pkg.sv
// wb_pkg
// Shared definitions for the writeback sequencer:
//   - writeback source codes (values driven onto the writeback mux select)
//   - FSM state encoding
//   - the latched request record
//   - needs_wait(): whether a source must be waited on before writing back
package wb_pkg;

    localparam logic [2:0] WB_ULA     = 3'd0;
    localparam logic [2:0] WB_SEXT1   = 3'd1;
    localparam logic [2:0] WB_SHIFT   = 3'd2;
    localparam logic [2:0] WB_HI      = 3'd3;
    localparam logic [2:0] WB_LO      = 3'd4;
    localparam logic [2:0] WB_SL16    = 3'd5;
    localparam logic [2:0] WB_LSCTRL  = 3'd6;
    localparam logic [2:0] WB_ILLEGAL = 3'd7;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_ERR   = 2'd3;

    typedef struct packed {
        logic [2:0] src;
        logic [4:0] dst;
    } wb_req_t;

    // Sources whose result is produced by a multicycle unit and therefore
    // has a done flag that must be observed before the write.
    function automatic logic needs_wait(input logic [2:0] src);
        logic w;
        w = 1'b0;
        case (src)
            WB_SHIFT, WB_HI, WB_LO, WB_LSCTRL: w = 1'b1;
            default:                           w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/wb_sequencer_timeout.sv
// wb_timeout_counter
// Counts cycles spent waiting for a source. Cleared by i_clear (and reset),
// advances by one on each i_enable cycle, and flags o_expired while the
// count sits at TIMEOUT-1, i.e. on the last permitted wait cycle.
// Ports:
//   i_clk      system clock
//   i_reset    synchronous active-high reset
//   i_clear    return count to zero (has priority over i_enable)
//   i_enable   advance count by one
//   o_expired  count == TIMEOUT-1
module wb_timeout_counter
    import wb_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = $clog2(TIMEOUT)
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == LAST);

endmodule

// File: rtl/wb_sequencer.sv
// wb_sequencer
// Writeback sequencer for the multicycle MIPS datapath. Accepts a writeback
// request, waits for the selected source to become valid (bounded by a
// timeout), then drives the writeback mux select and register-file write
// enable for exactly one cycle.
// Ports:
//   clk               system clock
//   reset             synchronous active-high reset
//   wb_start          request pulse, sampled only in IDLE
//   wb_src[2:0]       source code (7 is illegal)
//   wb_dst[4:0]       destination register
//   shift_done        shift register result valid (level)
//   muldiv_done       HI/LO valid (level)
//   mem_done          load data valid (level)
//   MEMtoREG_SELETOR  writeback mux select, bit 3 always 0
//   RegWrite          register-file write enable
//   wb_reg            register-file write address
//   wb_busy           high in every state except IDLE
//   wb_done           one-cycle pulse, writeback complete
//   wb_error          one-cycle pulse, request aborted
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no request in flight; wb_start accepted here only
// WAIT    | request latched, waiting for the source's done flag
// WRITE   | single write cycle (RegWrite suppressed for $zero)
// ERR     | illegal source or timeout; one-cycle wb_error, no write
module wb_sequencer
    import wb_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = $clog2(TIMEOUT)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wb_start,
    input  logic [2:0] wb_src,
    input  logic [4:0] wb_dst,
    input  logic       shift_done,
    input  logic       muldiv_done,
    input  logic       mem_done,
    output logic [3:0] MEMtoREG_SELETOR,
    output logic       RegWrite,
    output logic [4:0] wb_reg,
    output logic       wb_busy,
    output logic       wb_done,
    output logic       wb_error
);

    logic [1:0] r_state;
    wb_req_t    r_req;

    logic [3:0] r_sel;
    logic       r_regwrite;
    logic [4:0] r_reg;
    logic       r_busy;
    logic       r_done;
    logic       r_error;

    logic [1:0] w_state_nxt;
    wb_req_t    w_req_nxt;
    logic       w_ready;
    logic       w_expired;
    logic       w_cnt_clear;
    logic       w_cnt_enable;

    // Done flag belonging to the latched source; sources that never wait
    // (and the illegal code) read as not ready.
    always_comb begin
        w_ready = 1'b0;
        case (r_req.src)
            WB_SHIFT:     w_ready = shift_done;
            WB_HI, WB_LO: w_ready = muldiv_done;
            WB_LSCTRL:    w_ready = mem_done;
            default:      w_ready = 1'b0;
        endcase
    end

    // Counter holds zero outside WAIT, so it always starts a wait from zero.
    assign w_cnt_clear  = (r_state != S_WAIT);
    assign w_cnt_enable = (r_state == S_WAIT) && !w_ready;

    wb_timeout_counter #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_clear   (w_cnt_clear),
        .i_enable  (w_cnt_enable),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        case (r_state)
            S_IDLE: begin
                if (wb_start) begin
                    w_req_nxt.src = wb_src;
                    w_req_nxt.dst = wb_dst;
                    if (wb_src == WB_ILLEGAL) begin
                        w_state_nxt = S_ERR;
                    end else if (needs_wait(wb_src)) begin
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_state_nxt = S_WRITE;
                    end
                end
            end
            S_WAIT: begin
                // A ready seen on the last permitted cycle still wins.
                if (w_ready) begin
                    w_state_nxt = S_WRITE;
                end else if (w_expired) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_WRITE: w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state they describe rather than lagging it by a cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_req      <= '0;
            r_sel      <= 4'b0000;
            r_regwrite <= 1'b0;
            r_reg      <= 5'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_req      <= w_req_nxt;
            if ((w_state_nxt == S_WAIT) || (w_state_nxt == S_WRITE)) begin
                r_sel <= {1'b0, w_req_nxt.src};
                r_reg <= w_req_nxt.dst;
            end else begin
                r_sel <= 4'b0000;
                r_reg <= 5'd0;
            end
            r_regwrite <= (w_state_nxt == S_WRITE) && (w_req_nxt.dst != 5'd0);
            r_done     <= (w_state_nxt == S_WRITE);
            r_error    <= (w_state_nxt == S_ERR);
            r_busy     <= (w_state_nxt != S_IDLE);
        end
    end

    assign MEMtoREG_SELETOR = r_sel;
    assign RegWrite         = r_regwrite;
    assign wb_reg           = r_reg;
    assign wb_busy          = r_busy;
    assign wb_done          = r_done;
    assign wb_error         = r_error;

endmodule

// File: tb/tb_wb_sequencer.sv
// Testbench for wb_sequencer: directed requests push their expected
// completion (kind, select, write enable, register, cycle) into a queue;
// a monitor pops and compares whenever wb_done or wb_error pulses.
module tb_wb_sequencer;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       wb_start;
    logic [2:0] wb_src;
    logic [4:0] wb_dst;
    logic       shift_done;
    logic       muldiv_done;
    logic       mem_done;
    logic [3:0] sel;
    logic       RegWrite;
    logic [4:0] wb_reg;
    logic       wb_busy;
    logic       wb_done;
    logic       wb_error;

    always #5 clk = ~clk;

    wb_sequencer #(.TIMEOUT(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .wb_start         (wb_start),
        .wb_src           (wb_src),
        .wb_dst           (wb_dst),
        .shift_done       (shift_done),
        .muldiv_done      (muldiv_done),
        .mem_done         (mem_done),
        .MEMtoREG_SELETOR (sel),
        .RegWrite         (RegWrite),
        .wb_reg           (wb_reg),
        .wb_busy          (wb_busy),
        .wb_done          (wb_done),
        .wb_error         (wb_error)
    );

    typedef struct {
        logic       is_err;
        logic [3:0] sel;
        logic       rw;
        logic [4:0] rg;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (RegWrite) check("regwrite_outside_done", wb_done, 1);
        if (wb_done || wb_error) begin
            if (exp_q.size() == 0) begin
                check("unexpected_completion", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("error_flag", wb_error, mon_e.is_err);
                check("done_flag",  wb_done,  !mon_e.is_err);
                check("sel",        sel,      mon_e.sel);
                check("regwrite",   RegWrite, mon_e.rw);
                check("wb_reg",     wb_reg,   mon_e.rg);
                check("cycle",      cyc,      mon_e.cyc);
            end
        end
    end

    task automatic push(input logic is_err, input logic [3:0] s, input logic rw,
                        input logic [4:0] rg, input int dcyc);
        exp_t e;
        e.is_err = is_err;
        e.sel    = s;
        e.rw     = rw;
        e.rg     = rg;
        e.cyc    = cyc + dcyc;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic start(input logic [2:0] src, input logic [4:0] dst);
        wb_start = 1'b1;
        wb_src   = src;
        wb_dst   = dst;
        step();
        wb_start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sel"},   sel,      0);
        check({tag, "_rw"},    RegWrite, 0);
        check({tag, "_reg"},   wb_reg,   0);
        check({tag, "_busy"},  wb_busy,  0);
        check({tag, "_done"},  wb_done,  0);
        check({tag, "_error"}, wb_error, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d expectations outstanding", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; wb_start = 1'b0; wb_src = 3'd0; wb_dst = 5'd0;
        shift_done = 1'b0; muldiv_done = 1'b0; mem_done = 1'b0;
        step(2);
        check_all_zero("reset");
        reset = 1'b0;
        step();

        // ULA to r8: immediate write, then IDLE
        push(1'b0, 4'd0, 1'b1, 5'd8, 1);
        start(3'd0, 5'd8);
        check("ula_busy", wb_busy, 1);
        step();
        check("ula_idle", wb_busy, 0);

        // HI to r5, muldiv_done raised 4 cycles after start
        push(1'b0, 4'd3, 1'b1, 5'd5, 5);
        start(3'd3, 5'd5);
        for (int i = 0; i < 3; i++) begin
            check("hi_wait_busy", wb_busy, 1);
            check("hi_wait_sel", sel, 3);
            step();
        end
        muldiv_done = 1'b1;
        step();
        check("hi_write_busy", wb_busy, 1);
        muldiv_done = 1'b0;
        step();
        check("hi_idle", wb_busy, 0);

        // LO to r7 with muldiv_done already high: minimum latency 2
        muldiv_done = 1'b1;
        push(1'b0, 4'd4, 1'b1, 5'd7, 2);
        start(3'd4, 5'd7);
        check("lo_wait_reg", wb_reg, 7);
        step();
        muldiv_done = 1'b0;
        step();
        check("lo_idle", wb_busy, 0);

        // LScontrol with mem_done low: timeout; a start during WAIT is ignored
        push(1'b1, 4'd0, 1'b0, 5'd0, TO + 1);
        start(3'd6, 5'd4);
        step(2);
        wb_start = 1'b1; wb_src = 3'd0; wb_dst = 5'd9;
        step();
        wb_start = 1'b0;
        step(TO + 1 - 4);
        check("timeout_err_busy", wb_busy, 1);
        step();
        check("timeout_idle", wb_busy, 0);

        // SL16 to $zero: done without RegWrite
        push(1'b0, 4'd5, 1'b0, 5'd0, 1);
        start(3'd5, 5'd0);
        step();

        // illegal source: immediate error
        push(1'b1, 4'd0, 1'b0, 5'd0, 1);
        start(3'd7, 5'd3);
        step();

        // reset during WAIT drops the request; later shift_done writes nothing
        start(3'd2, 5'd10);
        check("rst_wait_busy", wb_busy, 1);
        step();
        reset = 1'b1;
        step();
        check_all_zero("midreset");
        reset = 1'b0;
        shift_done = 1'b1;
        step(3);
        shift_done = 1'b0;
        check("midreset_idle", wb_busy, 0);

        // shift_done sampled on the last permitted wait cycle wins over timeout
        push(1'b0, 4'd2, 1'b1, 5'd12, TO + 1);
        start(3'd2, 5'd12);
        step(TO - 1);
        shift_done = 1'b1;
        step();
        shift_done = 1'b0;
        step();
        check("race_idle", wb_busy, 0);

        // back-to-back: start during WRITE ignored, next accepted 2 cycles later
        push(1'b0, 4'd0, 1'b1, 5'd1, 1);
        start(3'd0, 5'd1);
        wb_start = 1'b1; wb_src = 3'd1; wb_dst = 5'd3;
        step();
        wb_start = 1'b0;
        push(1'b0, 4'd1, 1'b1, 5'd2, 1);
        start(3'd1, 5'd2);
        step(3);

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_sequencer.md
# wb_sequencer

Writeback sequencer for the multicycle MIPS datapath. It accepts a writeback request from the main control unit and waits until the selected source is valid. The sources are the ULA, the 1→32 sign extend, the shift register, HI, LO, the 16→32 shift-left and the load/store control. Once the source is valid it drives the writeback mux selector and the register-file write enable for exactly one cycle. Sources that cannot become valid are bounded by a timeout.

## Interface
- TIMEOUT, 64: maximum WAIT cycles before abort; legal range 2..1024.
- CNT_W, $clog2(TIMEOUT): width of the wait counter.

- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; returns the block to IDLE.
- wb_start  in  1  request pulse from main control; sampled only in IDLE.
- wb_src  in  3  source code: 0 ULA, 1 sign-extend 1→32, 2 shift reg, 3 HI, 4 LO, 5 SL 16→32, 6 LScontrol, 7 illegal.
- wb_dst  in  5  destination register number.
- shift_done  in  1  level; shift register result valid.
- muldiv_done  in  1  level; HI/LO valid.
- mem_done  in  1  level; LScontrol load data valid.
- MEMtoREG_SELETOR  out  4  mux select; bit 3 always 0.
- RegWrite  out  1  register-file write enable.
- wb_reg  out  5  register-file write address.
- wb_busy  out  1  high in every state except IDLE.
- wb_done  out  1  one-cycle pulse; writeback cycle complete.
- wb_error  out  1  one-cycle pulse; request aborted.

## Operation
- States: IDLE, WAIT, WRITE, ERR.
- IDLE, wb_start=1:
  - Latch wb_src and wb_dst.
  - src 0/1/5 → WRITE.
  - src 2/3/4/6 → WAIT with counter cleared.
  - src 7 → ERR.
- IDLE, wb_start=0: remain in IDLE.
- wb_start in any state other than IDLE is ignored; there is no queue.
- WAIT:
  - The ready for the latched source is shift_done (2), muldiv_done (3, 4) or mem_done (6).
  - Ready=1 → WRITE.
  - Otherwise, counter == TIMEOUT-1 → ERR.
  - Otherwise counter increments.
  - Ready wins over timeout in the same cycle.
- WRITE:
  - MEMtoREG_SELETOR = {1'b0, latched src}.
  - RegWrite = 1 unless latched dst == 0; writes to $zero are suppressed.
  - wb_done = 1 in both cases.
  - Next state is IDLE.
- ERR: wb_error = 1, RegWrite = 0, next state IDLE.
- MEMtoREG_SELETOR holds the latched src in WAIT and WRITE, and is 4'b0000 in IDLE and ERR.
- wb_reg holds the latched dst in WAIT and WRITE, and is 0 in IDLE and ERR.
- All outputs are registered and are a pure function of state plus latched fields.
- Reset values: state IDLE, MEMtoREG_SELETOR 0, RegWrite 0, wb_reg 0, wb_busy 0, wb_done 0, wb_error 0, counter 0, latched src/dst 0.

## Timing
- wb_start at edge n with an immediate source: RegWrite/wb_done high during cycle n+1, IDLE at n+2.
- Waiting source: WAIT from n+1. Ready first sampled high at edge m gives WRITE during cycle m+1. A ready already high at n is not used; it is re-sampled in WAIT, giving minimum latency 2.
- Timeout: with no ready, ERR occurs in cycle n+1+TIMEOUT and IDLE follows at n+2+TIMEOUT.
- Back-to-back requests: a new wb_start is accepted at the first IDLE edge, so the minimum spacing is 2 cycles for immediate sources.
- Reset asserted in any state forces IDLE on the next edge. A write in progress is dropped with no RegWrite or wb_done, and latched fields are cleared.
- Ready inputs that deassert during WAIT before being sampled high have no effect.

## Structure
- Shared package wb_pkg holds:
  - Source code constants WB_ULA..WB_LSCTRL and WB_ILLEGAL.
  - State encoding constants S_IDLE, S_WAIT, S_WRITE, S_ERR.
  - The function mapping a source code to its "needs wait" flag.
- Sub-module wb_timeout_counter (inputs clear and enable; output expired at TIMEOUT-1) is instantiated once.
- The FSM and output registers stay in wb_sequencer.

## Test plan
- wb_start, src=0, dst=8 → cycle n+1: SEL=0000, RegWrite=1, wb_reg=8, wb_done=1; IDLE at n+2.
- src=3, dst=5, muldiv_done raised 4 cycles after start → WRITE 1 cycle after the sampled ready with SEL=0011, RegWrite=1; wb_busy high throughout.
- src=6, TIMEOUT=8, mem_done held 0 → wb_error pulse in cycle n+9, RegWrite never asserted, IDLE at n+10.
- src=5, dst=0 → wb_done=1 with RegWrite=0. src=7 → wb_error at n+1 with no write.
- src=2 in WAIT, reset pulsed one cycle → all outputs 0 next cycle; a later shift_done causes no write. A wb_start during WAIT is ignored.
- shift_done and timeout in the same cycle (TIMEOUT=4, ready at count 3) → WRITE, not ERR.
